// File: rtl/parity_frame_checker.sv
// Serial odd/even parity frame checker: DATA_W data bits LSB first, then one parity bit.
// word_valid pulses 1 cycle after the parity bit; there is no backpressure, and bit_valid gaps are absorbed.
module parity_frame_checker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              frame_start,
  input  logic              odd_mode,
  input  logic              clr_cnt,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid,
  output logic              perr,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t              state_q, state_nxt;
  logic [DATA_W-1:0]   data_q, data_nxt;
  logic [IDX_W-1:0]    idx_q, idx_nxt;
  logic                odd_q, odd_nxt;
  logic                fin;
  logic                fin_perr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      odd_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      data_q  <= data_nxt;
      idx_q   <= idx_nxt;
      odd_q   <= odd_nxt;
    end
  end

  // Bits enter at the MSB and shift down, so after DATA_W bits the first one sits at bit 0.
  always_comb begin
    state_nxt = state_q;
    data_nxt  = data_q;
    idx_nxt   = idx_q;
    odd_nxt   = odd_q;
    fin       = 1'b0;
    fin_perr  = 1'b0;
    if (bit_valid && frame_start) begin
      data_nxt           = data_q >> 1;
      data_nxt[DATA_W-1] = bit_in;
      odd_nxt            = odd_mode;
      idx_nxt            = IDX_W'(1);
      state_nxt          = (DATA_W == 1) ? PARITY : DATA;
    end else if (bit_valid) begin
      case (state_q)
        DATA: begin
          data_nxt           = data_q >> 1;
          data_nxt[DATA_W-1] = bit_in;
          idx_nxt            = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) state_nxt = PARITY;
        end
        PARITY: begin
          fin       = 1'b1;
          fin_perr  = ((^data_q) ^ bit_in) != odd_q;
          state_nxt = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_valid <= 1'b0;
      word_out   <= '0;
      perr       <= 1'b0;
    end else begin
      word_valid <= fin;
      if (fin) begin
        word_out <= data_q;
        perr     <= fin_perr;
      end
    end
  end

  // Counts on the word_valid cycle itself; a clear in that cycle wins.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      err_cnt <= '0;
    end else if (word_valid && perr && err_cnt != CNT_MAX) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker: a table of frames plus abort, saturation and reset sequences.
module tb_parity_frame_checker;

  logic       clk = 1'b0;
  logic       rst, bit_in, bit_valid, frame_start, odd_mode, clr_cnt;
  logic [7:0] word8, word2;
  logic       wv8, wv2, perr8, perr2, busy8, busy2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  parity_frame_checker #(.DATA_W(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .odd_mode(odd_mode), .clr_cnt(clr_cnt),
    .word_out(word8), .word_valid(wv8), .perr(perr8), .err_cnt(cnt8), .busy(busy8)
  );

  parity_frame_checker #(.DATA_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .odd_mode(odd_mode), .clr_cnt(clr_cnt),
    .word_out(word2), .word_valid(wv2), .perr(perr2), .err_cnt(cnt2), .busy(busy2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] word;
    logic       perr;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       odd;
    logic       p;
    int         gap;
    logic       perr;
  } vec_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   checking = 1'b0;
  int   cnt8_m = 0;
  int   cnt2_m = 0;
  exp_t last = '{8'h00, 1'b0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: counters are modelled one cycle ahead from the inputs seen at this edge.
  always @(negedge clk) begin
    if (checking) begin
      logic inc;
      exp_t e;
      inc = 1'b0;
      chk("err_cnt8", 32'(cnt8), 32'(cnt8_m));
      chk("err_cnt2", 32'(cnt2), 32'(cnt2_m));
      if (wv8 === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_word_valid: word_valid=1 word_out=%0h with no frame pending", word8);
        end else begin
          e = q.pop_front();
          chk("word_out", 32'(word8), 32'(e.word));
          chk("perr", 32'(perr8), 32'(e.perr));
          chk("word_valid2", 32'(wv2), 32'd1);
          chk("word_out2", 32'(word2), 32'(e.word));
          chk("perr2", 32'(perr2), 32'(e.perr));
          last = e;
          inc  = e.perr;
        end
      end else begin
        chk("word_valid2_idle", 32'(wv2), 32'd0);
        chk("word_out_hold", 32'(word8), 32'(last.word));
        chk("perr_hold", 32'(perr8), 32'(last.perr));
      end
      if (rst) begin
        cnt8_m = 0;
        cnt2_m = 0;
        last   = '{8'h00, 1'b0};
      end else if (clr_cnt) begin
        cnt8_m = 0;
        cnt2_m = 0;
      end else if (inc) begin
        if (cnt8_m < 255) cnt8_m++;
        if (cnt2_m < 3) cnt2_m++;
      end
    end
  end

  task automatic idle(input int n);
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    repeat (n) step();
  endtask

  // frame_start is toggled with bit_valid low during gaps, and odd_mode flips after bit 0, to prove both are ignored.
  task automatic send_frame(input logic [7:0] d, input logic odd, input logic p,
                            input logic exp_perr, input int gap);
    for (int i = 0; i < 9; i++) begin
      if (i > 0 && gap > 0) begin
        bit_valid   = 1'b0;
        frame_start = 1'b1;
        bit_in      = 1'($urandom);
        repeat ($urandom_range(0, gap)) step();
      end
      bit_valid   = 1'b1;
      frame_start = (i == 0);
      odd_mode    = (i == 0) ? odd : ~odd;
      if (i < 8) begin
        bit_in = d[i];
      end else begin
        bit_in = p;
        q.push_back('{d, exp_perr});
      end
      step();
      if (i == 0) chk("busy_after_start", 32'(busy8), 32'd1);
    end
    bit_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic partial(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      bit_valid   = 1'b1;
      frame_start = (i == 0);
      odd_mode    = 1'b0;
      bit_in      = d[i];
      step();
    end
    bit_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  vec_t tbl[8];
  int   sat_exp[5];

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 0, 1'b0};
    tbl[1] = '{8'hA5, 1'b1, 1'b0, 0, 1'b1};
    tbl[2] = '{8'h01, 1'b0, 1'b1, 0, 1'b0};
    tbl[3] = '{8'h3C, 1'b0, 1'b0, 5, 1'b0};
    tbl[4] = '{8'hFF, 1'b1, 1'b1, 3, 1'b0};
    tbl[5] = '{8'h00, 1'b1, 1'b0, 0, 1'b1};
    tbl[6] = '{8'h80, 1'b0, 1'b1, 2, 1'b0};
    tbl[7] = '{8'h7F, 1'b1, 1'b0, 0, 1'b0};
    sat_exp = '{1, 2, 3, 3, 3};

    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
    odd_mode = 1'b0; clr_cnt = 1'b0;
    repeat (3) step();
    chk("rst_word_valid", 32'(wv8), 32'd0);
    chk("rst_word_out", 32'(word8), 32'd0);
    chk("rst_perr", 32'(perr8), 32'd0);
    chk("rst_err_cnt", 32'(cnt8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    checking = 1'b1;
    rst = 1'b0;
    idle(2);

    // Table frames run back to back: each frame_start lands in the previous word_valid cycle.
    for (int i = 0; i < 8; i++)
      send_frame(tbl[i].d, tbl[i].odd, tbl[i].p, tbl[i].perr, tbl[i].gap);
    idle(3);
    chk("busy_idle", 32'(busy8), 32'd0);
    chk("cnt_after_table", 32'(cnt8), 32'd2);

    partial(8'h55, 5);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 0);
    idle(2);
    partial(8'hC3, 8);
    chk("busy_in_parity", 32'(busy8), 32'd1);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 0);
    idle(3);
    chk("cnt_after_abort", 32'(cnt8), 32'd3);

    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("clr_cnt8", 32'(cnt8), 32'd0);
    chk("clr_cnt2", 32'(cnt2), 32'd0);
    for (int i = 0; i < 5; i++) begin
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 0);
      idle(2);
      chk("sat_cnt2", 32'(cnt2), 32'(sat_exp[i]));
      chk("sat_cnt8", 32'(cnt8), 32'(i + 1));
    end
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 0);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("clr_wins_cnt2", 32'(cnt2), 32'd0);
    chk("clr_wins_cnt8", 32'(cnt8), 32'd0);

    send_frame(8'h96, 1'b1, 1'b0, 1'b1, 0);
    idle(2);
    chk("pre_rst_cnt", 32'(cnt8), 32'd1);
    partial(8'hE7, 3);
    rst = 1'b1;
    step();
    chk("midrst_word_valid", 32'(wv8), 32'd0);
    chk("midrst_word_out", 32'(word8), 32'd0);
    chk("midrst_perr", 32'(perr8), 32'd0);
    chk("midrst_err_cnt", 32'(cnt8), 32'd0);
    chk("midrst_busy", 32'(busy8), 32'd0);
    rst = 1'b0;
    idle(3);
    send_frame(8'h00, 1'b1, 1'b1, 1'b0, 0);
    idle(3);
    chk("final_busy", 32'(busy8), 32'd0);
    chk("final_busy2", 32'(busy2), 32'd0);

    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk("pending_frames", 32'(q.size()), 32'd0);
    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
